// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MULTU/DIVU sequencer owning the HI/LO pair.
// One shift-add or restoring-subtract step per cycle; stalls colliding reads/starts.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hilo_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_LAST = CW'(1);

  logic [0:0]       state;
  logic             isDiv;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] loW;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   mulAcc;
  logic [WIDTH-1:0] mulLo;
  logic [WIDTH:0]   divShift;
  logic             divFits;
  logic [WIDTH:0]   divRem;
  logic [WIDTH-1:0] divQuot;
  logic [WIDTH:0]   nextAcc;
  logic [WIDTH-1:0] nextLo;

  assign busy     = (state == RUN);
  assign stall    = busy & (start | rd_hi | rd_lo);
  assign hilo_out = rd_hi ? hi : lo;

  // acc/loW hold either {hi-half, multiplier} or {rem, quot}
  always_comb begin
    mulSum   = acc + {1'b0, (loW[0] ? opnd : '0)};
    mulAcc   = {1'b0, mulSum[WIDTH:1]};
    mulLo    = {mulSum[0], loW[WIDTH-1:1]};
    divShift = {acc[WIDTH-1:0], loW[WIDTH-1]};
    divFits  = (divShift >= {1'b0, opnd});
    divRem   = divFits ? (divShift - {1'b0, opnd}) : divShift;
    divQuot  = {loW[WIDTH-2:0], divFits};
    nextAcc  = isDiv ? divRem : mulAcc;
    nextLo   = isDiv ? divQuot : mulLo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      isDiv       <= 1'b0;
      count       <= '0;
      acc         <= '0;
      loW         <= '0;
      opnd        <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            if (op && (b == '0)) begin
              hi          <= a;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              count <= COUNT_INIT;
              isDiv <= op;
              opnd  <= op ? b : a;
              loW   <= op ? a : b;
              acc   <= '0;
            end
          end
        end
        RUN: begin
          acc   <= nextAcc;
          loW   <= nextLo;
          count <= count - COUNT_LAST;
          if (count == COUNT_LAST) begin
            hi    <= nextAcc[WIDTH-1:0];
            lo    <= nextLo;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer.
// Reference results come from plain 64-bit arithmetic.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rd_hi = 1'b0;
  logic        rd_lo = 1'b0;
  logic        stall;
  logic        busy;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int total = 0;
  int bad = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .rd_hi(rd_hi), .rd_lo(rd_lo),
    .stall(stall), .busy(busy), .hilo_out(hilo_out),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refRes(input logic o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    logic [63:0] p;
    if (!o) p = {32'd0, x} * {32'd0, y};
    else if (y == 0) p = {x, 32'hFFFF_FFFF};
    else p = {x % y, x / y};
    return p;
  endfunction

  // Issue one op; returns busy-cycle count, ends at negedge of first idle cycle.
  task automatic issue(input logic o, input logic [31:0] x,
                       input logic [31:0] y, output int nBusy);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = $urandom; a = $urandom; b = $urandom;
    nBusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      nBusy++;
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({hi, lo, busy, stall, div_by_zero, hilo_out} !== '0) begin
      bad++;
      $display("FAIL reset_init: hi=%h lo=%h busy=%b stall=%b dbz=%b out=%h want all 0",
               hi, lo, busy, stall, div_by_zero, hilo_out);
    end
    issue(1'b0, 32'd3, 32'd5, n);
    total++;
    if (lo !== 32'd15) begin
      bad++;
      $display("FAIL reset_pre_op: lo=%h want 0000000f", lo);
    end
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; a = 32'd1000; b = 32'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({hi, lo, busy, stall, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_midrun: hi=%h lo=%h busy=%b stall=%b dbz=%b want all 0",
               hi, lo, busy, stall, div_by_zero);
    end
    repeat (40) @(negedge clk);
    total++;
    if ({hi, lo, busy} !== '0) begin
      bad++;
      $display("FAIL reset_abort: hi=%h lo=%h busy=%b want 0", hi, lo, busy);
    end
  endtask

  task automatic test_mul_max();
    int n;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL mul_busy: cycles=%0d want 32", n);
    end
    total++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++;
      $display("FAIL mul_max: hi=%h lo=%h want fffffffe 00000001", hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(1'b1, 32'd100, 32'd7, n);
    total++;
    if (n != 32 || hi !== 32'd2 || lo !== 32'd14 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL div_100_7: cycles=%0d hi=%0d lo=%0d dbz=%b want 32 2 14 0",
               n, hi, lo, div_by_zero);
    end
  endtask

  task automatic test_div_zero();
    int n;
    issue(1'b1, 32'h1234_5678, 32'd0, n);
    total++;
    if (n != 0 || hi !== 32'h1234_5678 || lo !== 32'hFFFF_FFFF || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL div_zero: cycles=%0d hi=%h lo=%h dbz=%b want 0 12345678 ffffffff 1",
               n, hi, lo, div_by_zero);
    end
    issue(1'b0, 32'd3, 32'd5, n);
    total++;
    if (div_by_zero !== 1'b0 || hi !== 32'd0 || lo !== 32'd15) begin
      bad++;
      $display("FAIL div_zero_clear: dbz=%b hi=%0d lo=%0d want 0 0 15",
               div_by_zero, hi, lo);
    end
  endtask

  task automatic test_read_stall();
    int nStall;
    logic [31:0] oldLo;
    logic leak;
    oldLo = lo;
    leak = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    rd_lo = 1'b1;
    nStall = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (stall === 1'b1) nStall++;
      if (hilo_out !== oldLo) leak = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (nStall != 32 || leak) begin
      bad++;
      $display("FAIL read_stall: stalled=%0d leak=%b want 32 0", nStall, leak);
    end
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || hilo_out !== 32'd42) begin
      bad++;
      $display("FAIL read_release: stall=%b out=%0d want 0 42", stall, hilo_out);
    end
    rd_lo = 1'b0;
    rd_hi = 1'b1;
    #1;
    total++;
    if (hilo_out !== 32'd0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL idle_mfhi: out=%h stall=%b want 0 0", hilo_out, stall);
    end
    rd_hi = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nStall;
    int nBusy;
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    op = 1'b1; a = 32'd9; b = 32'd2;
    nStall = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (stall === 1'b1) nStall++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (nStall != 32 || busy !== 1'b0 || stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
      bad++;
      $display("FAIL b2b_mid: stalled=%0d busy=%b stall=%b hi=%0d lo=%0d want 32 0 0 0 6",
               nStall, busy, stall, hi, lo);
    end
    @(posedge clk); #1;
    start = 1'b0;
    nBusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      nBusy++;
    end
    total++;
    if (nBusy != 32 || hi !== 32'd1 || lo !== 32'd4) begin
      bad++;
      $display("FAIL b2b_final: cycles=%0d hi=%0d lo=%0d want 32 1 4", nBusy, hi, lo);
    end
  endtask

  task automatic test_random();
    int n;
    logic o;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] exp;
    for (int k = 0; k < 24; k++) begin
      o = $urandom_range(0, 1);
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      if (k == 0) y = 32'd0;
      if (k == 1) begin o = 1'b1; x = 32'd5; y = 32'hFFFF_FFFF; end
      exp = refRes(o, x, y);
      issue(o, x, y, n);
      total++;
      if ({hi, lo} !== exp || div_by_zero !== (o && y == 0)
          || n != ((o && y == 0) ? 0 : 32)) begin
        bad++;
        $display("FAIL rand_%0d op=%b a=%h b=%h: hi=%h lo=%h dbz=%b cyc=%0d want %h %h",
                 k, o, x, y, hi, lo, div_by_zero, n, exp[63:32], exp[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_max();
    test_div();
    test_div_zero();
    test_read_stall();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
